result_drain: RTL and testbench

Reader side of the results SRAM. The vector-multiply datapath writes 768-bit result words (32 lanes x 24 b) into the SRAM. This block reads a programmed address range back out and serialises each word into narrower beats on a valid/ready stream to the host. A one-word prefetch keeps the stream free of bubbles.

---
 rtl/result_drain_pkg.sv | 22 ++
 rtl/result_drain_if.sv | 13 +
 rtl/drain_word_buf.sv | 53 +++++
 rtl/result_drain.sv | 133 +++++++++++++
 tb/tb_result_drain.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/result_drain_pkg.sv
// Shared constants and types for the results-SRAM drain path.
package result_drain_pkg;

    localparam int PARTIAL_SUM_BW = 24;
    localparam int MATRIX_SIZE    = 32;
    localparam int LANES_PER_BEAT = 8;
    localparam int BEATS          = MATRIX_SIZE / LANES_PER_BEAT;
    localparam int BEAT_CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int WORD_BW        = PARTIAL_SUM_BW * MATRIX_SIZE;
    localparam int BEAT_BW        = PARTIAL_SUM_BW * LANES_PER_BEAT;

    typedef logic [BEAT_CNT_W-1:0] beat_idx_t;
    typedef logic [WORD_BW-1:0]    word_t;
    typedef logic [BEAT_BW-1:0]    beat_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/result_drain_if.sv
// Valid/ready beat stream from the drain to the host.
interface result_drain_if;
    import result_drain_pkg::*;

    logic  m_valid;
    logic  m_ready;
    beat_t m_data;
    logic  m_last;

    modport master (output m_valid, m_data, m_last, input m_ready);
    modport slave  (input m_valid, m_data, m_last, output m_ready);

endinterface

// File: rtl/drain_word_buf.sv
// Two-entry result word buffer (current + prefetch) with the beat select mux.
module drain_word_buf
    import result_drain_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  word_t     push_data,
    input  logic      pop,
    input  beat_idx_t beat_idx,
    output logic      cur_valid,
    output logic      pre_valid,
    output beat_t     m_data
);

    word_t cur_word;
    word_t pre_word;

    always_ff @(posedge clk) begin
        // NOTE: the data words are reset too, so m_data reads 0 out of reset.
        if (rst) begin
            cur_word  <= '0;
            pre_word  <= '0;
            cur_valid <= 1'b0;
            pre_valid <= 1'b0;
        end else if (pop) begin
            if (pre_valid) begin
                // Prefetched word moves up in the same edge, so no bubble.
                cur_word  <= pre_word;
                pre_valid <= push;
                if (push) begin
                    pre_word <= push_data;
                end
            end else begin
                cur_valid <= push;
                if (push) begin
                    cur_word <= push_data;
                end
            end
        end else if (push) begin
            if (!cur_valid) begin
                cur_word  <= push_data;
                cur_valid <= 1'b1;
            end else begin
                pre_word  <= push_data;
                pre_valid <= 1'b1;
            end
        end
    end

    assign m_data = cur_word[int'(beat_idx) * BEAT_BW +: BEAT_BW];

endmodule

// File: rtl/result_drain.sv
// Drains a programmed range of results-SRAM words as a stream of narrower beats.
module result_drain
    import result_drain_pkg::*;
#(
    parameter int ADDRESSSIZE = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDRESSSIZE-1:0] base_addr,
    input  logic [ADDRESSSIZE:0]   num_words,
    output logic                   busy,
    output logic                   done,
    output logic                   sram_rd_en,
    output logic [ADDRESSSIZE-1:0] sram_address,
    input  word_t                  sram_data_out,
    result_drain_if.master         m
);

    localparam logic [ADDRESSSIZE-1:0] ADDR_ONE = {{(ADDRESSSIZE-1){1'b0}}, 1'b1};
    localparam logic [ADDRESSSIZE:0]   CNT_ONE  = {{ADDRESSSIZE{1'b0}}, 1'b1};
    localparam beat_idx_t              LAST_IDX = beat_idx_t'(BEATS - 1);
    localparam beat_idx_t              IDX_ONE  = beat_idx_t'(1);

    state_t                 state, state_next;
    logic [ADDRESSSIZE-1:0] next_addr;
    logic [ADDRESSSIZE:0]   words_to_issue;
    logic [ADDRESSSIZE:0]   words_out;
    beat_idx_t              beat_idx;
    logic                   rd_pending;
    logic                   cur_valid, pre_valid;
    beat_t                  beat_data;

    logic m_valid_int, m_last_int, transfer, last_beat, pop, buf_free, launch, issue;

    assign last_beat   = (beat_idx == LAST_IDX);
    assign m_valid_int = cur_valid && (state == RUN);
    assign m_last_int  = m_valid_int && last_beat && (words_out == CNT_ONE);
    assign transfer    = m_valid_int && m.m_ready;
    assign pop         = transfer && last_beat;
    assign launch      = (state == IDLE) && start && (num_words != '0);

    // Issue needs no read in flight, so nothing else can land before this
    // read does; a slot is free if one is empty now or is retiring this edge.
    assign buf_free = !(cur_valid && pre_valid) || pop;
    assign issue    = (state == RUN) && (words_to_issue != '0) &&
                      !sram_rd_en && !rd_pending && buf_free;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (num_words == '0) ? FIN : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (transfer && m_last_int) begin
                    state_next = FIN;
                end
            end
            FIN: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state is written with non-blocking assignments only.
        if (rst) begin
            sram_rd_en     <= 1'b0;
            sram_address   <= '0;
            next_addr      <= '0;
            words_to_issue <= '0;
            words_out      <= '0;
            beat_idx       <= '0;
            rd_pending     <= 1'b0;
        end else begin
            rd_pending <= sram_rd_en;
            sram_rd_en <= 1'b0;
            if (launch) begin
                sram_rd_en     <= 1'b1;
                sram_address   <= base_addr;
                next_addr      <= base_addr + ADDR_ONE;
                words_to_issue <= num_words - CNT_ONE;
                words_out      <= num_words;
                beat_idx       <= '0;
            end else if (issue) begin
                sram_rd_en     <= 1'b1;
                sram_address   <= next_addr;
                next_addr      <= next_addr + ADDR_ONE;
                words_to_issue <= words_to_issue - CNT_ONE;
            end
            if (transfer) begin
                beat_idx <= last_beat ? '0 : beat_idx + IDX_ONE;
                if (last_beat) begin
                    words_out <= words_out - CNT_ONE;
                end
            end
        end
    end

    drain_word_buf u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (rd_pending),
        .push_data (sram_data_out),
        .pop       (pop),
        .beat_idx  (beat_idx),
        .cur_valid (cur_valid),
        .pre_valid (pre_valid),
        .m_data    (beat_data)
    );

    assign m.m_valid = m_valid_int;
    assign m.m_last  = m_last_int;
    assign m.m_data  = beat_data;

endmodule

// File: tb/tb_result_drain.sv
// Directed self-checking bench for result_drain.
module tb_result_drain;
    import result_drain_pkg::*;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   num_words;
    logic          busy, done, sram_rd_en;
    logic [AW-1:0] sram_address;
    word_t         sram_data_out = '0;

    result_drain_if s_if();

    result_drain #(.ADDRESSSIZE(AW)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .base_addr     (base_addr),
        .num_words     (num_words),
        .busy          (busy),
        .done          (done),
        .sram_rd_en    (sram_rd_en),
        .sram_address  (sram_address),
        .sram_data_out (sram_data_out),
        .m             (s_if)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Lane j of the word at address a holds a*256 + j.
    function automatic word_t sram_word(input logic [AW-1:0] a);
        word_t w;
        for (int j = 0; j < MATRIX_SIZE; j++)
            w[j*PARTIAL_SUM_BW +: PARTIAL_SUM_BW] = PARTIAL_SUM_BW'(int'(a) * 256 + j);
        return w;
    endfunction

    function automatic beat_t exp_beat(input logic [AW-1:0] a, input int k);
        beat_t b;
        for (int l = 0; l < LANES_PER_BEAT; l++)
            b[l*PARTIAL_SUM_BW +: PARTIAL_SUM_BW] =
                PARTIAL_SUM_BW'(int'(a) * 256 + k * LANES_PER_BEAT + l);
        return b;
    endfunction

    always @(posedge clk) if (sram_rd_en) sram_data_out <= sram_word(sram_address);

    // Monitor, sampled on the falling edge.
    logic  clr = 1'b0;
    beat_t beats[$];
    logic  lasts[$];
    int    rd_addrs[$];
    int    done_count = 0, done_cyc = -1, first_rd = -1, first_valid = -1;
    int    last_xfer = -1, valid_cycles = 0, stall_err = 0;
    logic  busy_at_done = 1'b0, prev_stalled = 1'b0, prev_last = 1'b0;
    beat_t prev_data = '0;

    always @(negedge clk) begin
        if (clr) begin
            beats.delete(); lasts.delete(); rd_addrs.delete();
            done_count <= 0; done_cyc <= -1; first_rd <= -1; first_valid <= -1;
            last_xfer <= -1; valid_cycles <= 0; stall_err <= 0;
            busy_at_done <= 1'b0; prev_stalled <= 1'b0;
        end else begin
            if (s_if.m_valid) begin
                valid_cycles <= valid_cycles + 1;
                if (first_valid < 0) first_valid <= cyc;
            end
            if (sram_rd_en) begin
                rd_addrs.push_back(int'(sram_address));
                if (first_rd < 0) first_rd <= cyc;
            end
            if (s_if.m_valid && s_if.m_ready) begin
                beats.push_back(s_if.m_data);
                lasts.push_back(s_if.m_last);
                last_xfer <= cyc;
            end
            if (done) begin
                done_count   <= done_count + 1;
                done_cyc     <= cyc;
                busy_at_done <= busy;
            end
            if (prev_stalled && (!s_if.m_valid || s_if.m_data != prev_data ||
                                 s_if.m_last != prev_last))
                stall_err <= stall_err + 1;
            prev_stalled <= s_if.m_valid && !s_if.m_ready;
            prev_data    <= s_if.m_data;
            prev_last    <= s_if.m_last;
        end
    end

    int n_checks = 0, n_pass = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic clear_monitor();
        clr = 1'b1;
        @(negedge clk);
        #1 clr = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic run_drain(input string tag, input logic [AW-1:0] base, input int n,
                             input bit stall, input bit poke);
        int start_edge, budget, ea;
        bit seen_done;
        clear_monitor();
        base_addr     = base;
        num_words     = (AW+1)'(n);
        start         = 1'b1;
        s_if.m_ready  = 1'b1;
        start_edge    = cyc + 1;
        budget        = 0;
        seen_done     = 1'b0;
        while (!seen_done && budget < 500) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            budget++;
            s_if.m_ready = stall ? ((budget % 4 == 0) || (budget % 4 == 3)) : 1'b1;
            if (poke && budget == 6) begin
                start     = 1'b1;
                base_addr = 10'd100;
                num_words = 11'd1;
            end
            if (done_count > 0) seen_done = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_done_seen"}, seen_done, 1);
        check({tag, "_done_count"}, done_count, 1);
        check({tag, "_busy_at_done"}, busy_at_done, 0);
        check({tag, "_stall_hold"}, stall_err, 0);
        check({tag, "_nbeats"}, beats.size(), n * BEATS);
        for (int i = 0; i < beats.size() && i < n * BEATS; i++) begin
            ea = (int'(base) + i / BEATS) % (1 << AW);
            check($sformatf("%s_data%0d", tag, i), beats[i], exp_beat(AW'(ea), i % BEATS));
            check($sformatf("%s_last%0d", tag, i), lasts[i], (i == n * BEATS - 1));
        end
        check({tag, "_nreads"}, rd_addrs.size(), n);
        for (int i = 0; i < rd_addrs.size() && i < n; i++)
            check($sformatf("%s_addr%0d", tag, i), rd_addrs[i], (int'(base) + i) % (1 << AW));
        if (n > 0) begin
            check({tag, "_first_rd_cyc"}, first_rd, start_edge);
            check({tag, "_first_valid_cyc"}, first_valid, start_edge + 2);
            check({tag, "_done_cyc"}, done_cyc, last_xfer + 1);
            if (!stall) check({tag, "_valid_cycles"}, valid_cycles, n * BEATS);
        end else begin
            check({tag, "_no_read"}, first_rd, -1);
            check({tag, "_no_valid"}, first_valid, -1);
            check({tag, "_done_cyc"}, done_cyc, start_edge);
        end
    endtask

    initial begin
        int budget;
        rst          = 1'b1;
        start        = 1'b0;
        base_addr    = '0;
        num_words    = '0;
        s_if.m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_en", sram_rd_en, 0);
        check("rst_addr", sram_address, 0);
        check("rst_valid", s_if.m_valid, 0);
        check("rst_last", s_if.m_last, 0);
        check("rst_data", s_if.m_data, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_drain("t1", 10'd0, 1, 1'b0, 1'b0);
        run_drain("t2", 10'd5, 3, 1'b0, 1'b0);
        run_drain("t3", 10'd5, 3, 1'b1, 1'b1);
        run_drain("t4", 10'd1022, 4, 1'b0, 1'b0);
        run_drain("t5", 10'd7, 0, 1'b0, 1'b0);

        // Reset after the fifth beat of a three-word drain.
        clear_monitor();
        base_addr = 10'd5;
        num_words = 11'd3;
        start     = 1'b1;
        budget    = 0;
        while (beats.size() < 5 && budget < 200) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            budget++;
        end
        check("t6_reached_beat5", (beats.size() >= 5), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t6_busy_after_rst", busy, 0);
        check("t6_valid_after_rst", s_if.m_valid, 0);
        check("t6_rd_en_after_rst", sram_rd_en, 0);
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("t6_no_done", done_count, 0);
        check("t6_idle_valid", s_if.m_valid, 0);
        run_drain("t6b", 10'd40, 1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
